// File: rtl/arbitro_memoria_datos_if.sv
// Data-memory port bundle: MEM-stage request, memory-side strobes/data and the debug dump stream.
// master = the arbiter, slave = the surrounding pipeline/memory/debug logic.
interface arbitro_memoria_datos_if #(
  parameter int NBITS = 32
);
  logic             i_MemRead;
  logic             i_MemWrite;
  logic [NBITS-1:0] i_ALUDireccion;
  logic [NBITS-1:0] i_DatoRegistro;
  logic [NBITS-1:0] i_MemDatoLeido;
  logic [NBITS-1:0] o_MemDireccion;
  logic [NBITS-1:0] o_MemDato;
  logic             o_MemRead;
  logic             o_MemWrite;
  logic             o_PipeStall;
  logic             i_DumpStart;
  logic             i_DumpAbort;
  logic             i_DumpReady;
  logic             o_DumpValid;
  logic [NBITS-1:0] o_DumpDir;
  logic [NBITS-1:0] o_DumpDato;
  logic             o_DumpBusy;
  logic             o_DumpDone;

  modport master (
    input  i_MemRead, i_MemWrite, i_ALUDireccion, i_DatoRegistro, i_MemDatoLeido,
    input  i_DumpStart, i_DumpAbort, i_DumpReady,
    output o_MemDireccion, o_MemDato, o_MemRead, o_MemWrite, o_PipeStall,
    output o_DumpValid, o_DumpDir, o_DumpDato, o_DumpBusy, o_DumpDone
  );

  modport slave (
    output i_MemRead, i_MemWrite, i_ALUDireccion, i_DatoRegistro, i_MemDatoLeido,
    output i_DumpStart, i_DumpAbort, i_DumpReady,
    input  o_MemDireccion, o_MemDato, o_MemRead, o_MemWrite, o_PipeStall,
    input  o_DumpValid, o_DumpDir, o_DumpDato, o_DumpBusy, o_DumpDone
  );
endinterface

// File: rtl/arbitro_memoria_datos.sv
// Data-memory port arbiter (MEM stage wins) plus a memory dump streamer; 3 cycles/word, OUT holds until i_DumpReady.
// ARBITRO_STARVE_GUARD_EN: after STARVE_LIMIT blocked ISSUE cycles, stall the pipeline one cycle to force a dump read.
module arbitro_memoria_datos #(
  parameter int NBITS        = 32,
  parameter int CELDAS       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  arbitro_memoria_datos_if.master bus
);
  localparam int CW = (CELDAS > 1) ? $clog2(CELDAS) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] dir_q, dir_d;
  logic [NBITS-1:0] dato_q, dato_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             pipe_acc;
  logic             force_grant;
  logic             pipe_owns;
  logic             dump_rd;
  logic [NBITS-1:0] dump_addr;

  assign pipe_acc  = bus.i_MemRead | bus.i_MemWrite;
  assign dump_addr = NBITS'(cnt_q);

`ifdef ARBITRO_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign force_grant = (state_q == ISSUE) && (starve_q == SW'(STARVE_LIMIT));

  // Counts only cycles that stay in ISSUE because the pipeline held the port.
  always_comb begin
    starve_d = '0;
    if ((state_q == ISSUE) && (state_d == ISSUE) && pipe_acc && !force_grant)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) starve_q <= '0;
    else            starve_q <= starve_d;
  end
`else
  logic unused_starve_lim;
  assign unused_starve_lim = (STARVE_LIMIT == 0);
  assign force_grant       = 1'b0;
`endif

  assign pipe_owns = pipe_acc && !force_grant;
  assign dump_rd   = (state_q == ISSUE) && (!pipe_acc || force_grant);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    dato_d  = dato_q;
    case (state_q)
      IDLE: begin
        if (bus.i_DumpStart) begin
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (dump_rd) state_d = WAIT;
      end
      WAIT: begin
        // Memory read register now holds the word requested in ISSUE.
        dato_d  = bus.i_MemDatoLeido;
        dir_d   = dump_addr;
        state_d = OUT;
      end
      OUT: begin
        if (bus.i_DumpReady) begin
          if (cnt_q == CW'(CELDAS - 1)) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.i_DumpAbort && (state_q != IDLE)) state_d = IDLE;

    valid_d = (state_d == OUT);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= '0;
      dato_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      dato_q  <= dato_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_MemDireccion = pipe_owns ? bus.i_ALUDireccion : dump_addr;
  assign bus.o_MemDato      = bus.i_DatoRegistro;
  assign bus.o_MemRead      = i_reset_n & (pipe_owns ? bus.i_MemRead : dump_rd);
  assign bus.o_MemWrite     = i_reset_n & bus.i_MemWrite & ~force_grant;
  assign bus.o_PipeStall    = force_grant;
  assign bus.o_DumpValid    = valid_q;
  assign bus.o_DumpDir      = dir_q;
  assign bus.o_DumpDato     = dato_q;
  assign bus.o_DumpBusy     = busy_q;
  assign bus.o_DumpDone     = done_q;
endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Bench for arbitro_memoria_datos: memory preloaded with mem[a] = 2a, per-cycle stimulus tables,
// expected dump timeline derived from the word-by-word issue/accept rules.
module tb_arbitro_memoria_datos;
  localparam int NB     = 32;
  localparam int CEL    = 16;
  localparam int LIM    = 8;
  localparam int MAXC   = 300;
`ifdef ARBITRO_STARVE_GUARD_EN
  localparam bit GUARD  = 1'b1;
`else
  localparam bit GUARD  = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic preload;
  int   n_cmp;
  int   n_err;

  arbitro_memoria_datos_if #(.NBITS(NB)) bus ();

  arbitro_memoria_datos #(.NBITS(NB), .CELDAS(CEL), .STARVE_LIMIT(LIM)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with a registered read port.
  logic [NB-1:0] mem [32];
  logic [NB-1:0] rdata_q;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= NB'(2 * i);
    end else if (bus.o_MemWrite) begin
      mem[bus.o_MemDireccion[4:0]] <= bus.o_MemDato;
    end
    if (bus.o_MemRead) rdata_q <= mem[bus.o_MemDireccion[4:0]];
  end
  assign bus.i_MemDatoLeido = rdata_q;

  // Stimulus tables, indexed by cycle (cycle 0 = the cycle i_DumpStart is sampled).
  bit            s_rd   [MAXC];
  bit            s_wr   [MAXC];
  bit            s_rdy  [MAXC];
  logic [NB-1:0] s_addr [MAXC];
  logic [NB-1:0] s_dat  [MAXC];

  // Expected timeline.
  int e_issue [MAXC];
  bit e_stall [MAXC];
  int ev_start [CEL];
  int ev_acc   [CEL];
  int e_done;

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      s_rd[c]   = 1'b0;
      s_wr[c]   = 1'b0;
      s_rdy[c]  = 1'b1;
      s_addr[c] = '0;
      s_dat[c]  = '0;
    end
  endtask

  // Each word needs one ISSUE cycle free of pipeline traffic (or a forced grant after LIM
  // blocked cycles), becomes valid two cycles later and is held until the first ready cycle.
  task automatic build_model();
    int t;
    int a;
    int b;
    for (int c = 0; c < MAXC; c++) begin
      e_issue[c] = -1;
      e_stall[c] = 1'b0;
    end
    t = 1;
    for (int k = 0; k < CEL; k++) begin
      b = 0;
      while ((t < MAXC - 8) && (s_rd[t] || s_wr[t]) && !(GUARD && b == LIM)) begin
        b++;
        t++;
      end
      e_issue[t] = k;
      if (GUARD && b == LIM) e_stall[t] = 1'b1;
      a = t + 2;
      ev_start[k] = a;
      while ((a < MAXC - 8) && !s_rdy[a]) a++;
      ev_acc[k] = a;
      t = a + 1;
    end
    e_done = t;
  endtask

  task automatic idle_inputs();
    bus.i_MemRead      = 1'b0;
    bus.i_MemWrite     = 1'b0;
    bus.i_ALUDireccion = '0;
    bus.i_DatoRegistro = '0;
    bus.i_DumpStart    = 1'b0;
    bus.i_DumpAbort    = 1'b0;
    bus.i_DumpReady    = 1'b0;
  endtask

  task automatic run_dump(input string name);
    int  wk;
    bit  exp_v;
    bit  exp_rd;
    bit  pipe;
    build_model();
    wk = 0;
    for (int c = 0; c <= e_done + 2; c++) begin
      bus.i_DumpStart    = (c == 0);
      bus.i_MemRead      = s_rd[c];
      bus.i_MemWrite     = s_wr[c];
      bus.i_ALUDireccion = s_addr[c];
      bus.i_DatoRegistro = s_dat[c];
      bus.i_DumpReady    = s_rdy[c];
      @(negedge clk);
      pipe  = s_rd[c] || s_wr[c];
      exp_v = (wk < CEL) && (c >= ev_start[wk]) && (c <= ev_acc[wk]);
      n_cmp++;
      if (bus.o_DumpValid !== exp_v) begin
        n_err++;
        $display("FAIL %s valid c=%0d got=%b exp=%b", name, c, bus.o_DumpValid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (bus.o_DumpDir !== NB'(wk) || bus.o_DumpDato !== NB'(2 * wk)) begin
          n_err++;
          $display("FAIL %s word c=%0d got=(%0d,%0d) exp=(%0d,%0d)", name, c,
                   bus.o_DumpDir, bus.o_DumpDato, wk, 2 * wk);
        end
      end
      n_cmp++;
      if (bus.o_DumpDone !== (c == e_done)) begin
        n_err++;
        $display("FAIL %s done c=%0d got=%b exp=%b", name, c, bus.o_DumpDone, (c == e_done));
      end
      n_cmp++;
      if (bus.o_DumpBusy !== (c >= 1 && c <= e_done)) begin
        n_err++;
        $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, bus.o_DumpBusy, (c >= 1 && c <= e_done));
      end
      n_cmp++;
      if (bus.o_PipeStall !== e_stall[c]) begin
        n_err++;
        $display("FAIL %s stall c=%0d got=%b exp=%b", name, c, bus.o_PipeStall, e_stall[c]);
      end
      exp_rd = e_stall[c] ? 1'b1 : (pipe ? s_rd[c] : (e_issue[c] >= 0));
      n_cmp++;
      if (bus.o_MemRead !== exp_rd) begin
        n_err++;
        $display("FAIL %s memread c=%0d got=%b exp=%b", name, c, bus.o_MemRead, exp_rd);
      end
      n_cmp++;
      if (bus.o_MemWrite !== (s_wr[c] && !e_stall[c])) begin
        n_err++;
        $display("FAIL %s memwrite c=%0d got=%b exp=%b", name, c, bus.o_MemWrite, (s_wr[c] && !e_stall[c]));
      end
      if (e_issue[c] >= 0) begin
        n_cmp++;
        if (bus.o_MemDireccion !== NB'(e_issue[c])) begin
          n_err++;
          $display("FAIL %s dumpaddr c=%0d got=%0d exp=%0d", name, c, bus.o_MemDireccion, e_issue[c]);
        end
      end else if (pipe) begin
        n_cmp++;
        if (bus.o_MemDireccion !== s_addr[c] || bus.o_MemDato !== s_dat[c]) begin
          n_err++;
          $display("FAIL %s pipeaddr c=%0d got=%h/%h exp=%h/%h", name, c,
                   bus.o_MemDireccion, bus.o_MemDato, s_addr[c], s_dat[c]);
        end
      end
      if (exp_v && c == ev_acc[wk]) wk++;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    preload = 1'b1;
    idle_inputs();
    bus.i_MemRead   = 1'b1;
    bus.i_MemWrite  = 1'b1;
    bus.i_DumpStart = 1'b1;
    #3;
    n_cmp++;
    if ({bus.o_MemRead, bus.o_MemWrite, bus.o_PipeStall} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_strobes got=%b exp=000", {bus.o_MemRead, bus.o_MemWrite, bus.o_PipeStall});
    end
    @(posedge clk); #1;
    preload = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.o_DumpValid, bus.o_DumpDone, bus.o_DumpBusy} !== 3'b000 ||
        bus.o_DumpDir !== '0 || bus.o_DumpDato !== '0) begin
      n_err++;
      $display("FAIL reset_dump got=%b dir=%0d dato=%0d exp=000/0/0",
               {bus.o_DumpValid, bus.o_DumpDone, bus.o_DumpBusy}, bus.o_DumpDir, bus.o_DumpDato);
    end
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_dump();
    clear_stim();
    run_dump("full");
  endtask

  task automatic test_pipe_contention();
    clear_stim();
    for (int c = 4; c <= 6; c++) begin
      s_rd[c]   = 1'b1;
      s_addr[c] = NB'($urandom_range(0, 31));
    end
    run_dump("contention");
  endtask

  task automatic test_ready_stall();
    clear_stim();
    for (int c = 9; c <= 13; c++) s_rdy[c] = 1'b0;
    run_dump("ready_stall");
  endtask

  task automatic test_random_traffic();
    clear_stim();
    for (int c = 1; c < 200; c++) begin
      s_rd[c]   = ($urandom_range(0, 3) == 0);
      s_addr[c] = NB'($urandom_range(0, 31));
      s_dat[c]  = NB'($urandom);
      s_rdy[c]  = ($urandom_range(0, 3) != 0);
    end
    run_dump("random");
  endtask

  task automatic test_abort();
    idle_inputs();
    for (int c = 0; c <= 24; c++) begin
      bus.i_DumpStart = (c == 0);
      bus.i_DumpReady = 1'b1;
      bus.i_DumpAbort = (c == 24);
      @(negedge clk);
      if (c == 24) begin
        n_cmp++;
        if (bus.o_DumpValid !== 1'b1 || bus.o_DumpDir !== NB'(7) || bus.o_DumpDato !== NB'(14)) begin
          n_err++;
          $display("FAIL abort_word7 got=%b (%0d,%0d) exp=1 (7,14)",
                   bus.o_DumpValid, bus.o_DumpDir, bus.o_DumpDato);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_DumpValid, bus.o_DumpDone, bus.o_DumpBusy} !== 3'b000) begin
        n_err++;
        $display("FAIL abort_idle c=%0d got=%b exp=000", c,
                 {bus.o_DumpValid, bus.o_DumpDone, bus.o_DumpBusy});
      end
      @(posedge clk); #1;
    end
    clear_stim();
    run_dump("restart");
  endtask

  task automatic test_async_reset();
    idle_inputs();
    for (int c = 0; c <= 9; c++) begin
      bus.i_DumpStart = (c == 0);
      bus.i_DumpReady = (c != 9);
      @(negedge clk);
      if (c == 9) begin
        n_cmp++;
        if (bus.o_DumpValid !== 1'b1 || bus.o_DumpDir !== NB'(2)) begin
          n_err++;
          $display("FAIL arst_pre got=%b dir=%0d exp=1 dir=2", bus.o_DumpValid, bus.o_DumpDir);
        end
        #1;
        rst_n          = 1'b0;
        bus.i_MemRead  = 1'b1;
        bus.i_MemWrite = 1'b1;
        #1;
        n_cmp++;
        if ({bus.o_DumpValid, bus.o_DumpDone, bus.o_DumpBusy, bus.o_PipeStall,
             bus.o_MemRead, bus.o_MemWrite} !== 6'b0 ||
            bus.o_DumpDir !== '0 || bus.o_DumpDato !== '0) begin
          n_err++;
          $display("FAIL arst_outputs got=%b dir=%0d dato=%0d exp=0",
                   {bus.o_DumpValid, bus.o_DumpDone, bus.o_DumpBusy, bus.o_PipeStall,
                    bus.o_MemRead, bus.o_MemWrite}, bus.o_DumpDir, bus.o_DumpDato);
        end
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_DumpValid, bus.o_DumpDone, bus.o_DumpBusy} !== 3'b000) begin
        n_err++;
        $display("FAIL arst_idle c=%0d got=%b exp=000", c,
                 {bus.o_DumpValid, bus.o_DumpDone, bus.o_DumpBusy});
      end
      @(posedge clk); #1;
    end
    clear_stim();
    run_dump("after_reset");
  endtask

  // Constant MEM-stage writes to cells outside the dumped range.
  task automatic test_starve();
    clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      s_wr[c]   = GUARD ? 1'b1 : (c < 60);
      s_addr[c] = NB'(16 + $urandom_range(0, 15));
      s_dat[c]  = NB'($urandom);
    end
    run_dump("starve");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_full_dump();
    test_pipe_contention();
    test_ready_stall();
    test_random_traffic();
    test_abort();
    test_async_reset();
    test_starve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
